pulse_src_gate: RTL and testbench

Rate-limiting event gate in the `clksrc` domain, directly upstream of the pulse synchronizer's `pulse_src` input. The synchronizer loses any source pulse that arrives while a previous one is still in its stretch/acknowledge round trip. This block accepts arbitrarily dense event strobes, counts them in a saturating pending counter, and re-issues them as single-cycle pulses. Consecutive pulses are spaced at least `HOLDOFF`+1 `clksrc` cycles apart, so every issued pulse crosses the synchronizer intact.

---
 rtl/pulse_src_gate_pkg.sv | 9 +
 rtl/pulse_src_gate.sv | 128 ++++++++++++
 tb/tb_pulse_src_gate.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pulse_src_gate_pkg.sv
// Shared types and limits for the clksrc-domain event gate that feeds the
// pulse synchronizer.
package pulse_src_gate_pkg;

   typedef enum logic [1:0] {IDLE, FIRE, HOLD} gate_state_e;

   localparam int HOLDOFF_MIN = 1;

endpackage

// File: rtl/pulse_src_gate.sv
// Rate-limiting event gate: counts dense ev_in strobes and re-issues them as
// single-cycle pulses spaced HOLDOFF+1 clksrc cycles apart.
module pulse_src_gate
   import pulse_src_gate_pkg::*;
#(
   parameter int CNT_W   = 4,
   parameter int HOLDOFF = 16
) (
   input  logic             clksrc,
   input  logic             resetb_clksrc,
   input  logic             ev_in,
   input  logic             clr_ovf,
   output logic             pulse_src,
   output logic [CNT_W-1:0] pending,
   output logic             busy,
   output logic             overflow
);

   localparam int                 HCNT_W    = $clog2(HOLDOFF + 1);
   localparam logic [HCNT_W-1:0]  HOLD_LOAD = HCNT_W'(HOLDOFF - 1);
   localparam logic [CNT_W-1:0]   PEND_MAX  = '1;

   generate
      if (HOLDOFF < HOLDOFF_MIN || CNT_W < 1) begin : g_param_err
         $error("pulse_src_gate: HOLDOFF must be >= %0d and CNT_W >= 1", HOLDOFF_MIN);
      end
   endgenerate

   gate_state_e        state_q;
   gate_state_e        state_d;
   logic [HCNT_W-1:0]  hold_cnt_q;
   logic [HCNT_W-1:0]  hold_cnt_d;
   logic [CNT_W-1:0]   pending_q;
   logic [CNT_W-1:0]   pending_d;
   logic               pulse_q;
   logic               ovf_q;
   logic               ovf_d;
   logic               enter_fire;
   logic               ev_accept;
   logic               ev_drop;

   // State register
   always_ff @(posedge clksrc or negedge resetb_clksrc) begin
      if (!resetb_clksrc) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; depends only on registered values
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pending_q != '0) begin
               state_d = FIRE;
            end
         end
         FIRE: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = (pending_q != '0) ? FIRE : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign enter_fire = (state_d == FIRE);

   // Output decode
   always_comb begin
      busy = (state_q != IDLE) || (pending_q != '0);
   end

   // A full counter still accepts an event when a pulse is leaving on the same edge
   always_comb begin
      ev_accept = ev_in && ((pending_q != PEND_MAX) || enter_fire);
      ev_drop   = ev_in && !ev_accept;
      pending_d = pending_q;
      case ({ev_accept, enter_fire})
         2'b10:   pending_d = pending_q + CNT_W'(1);
         2'b01:   pending_d = pending_q - CNT_W'(1);
         default: pending_d = pending_q;
      endcase
      ovf_d = ev_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clksrc or negedge resetb_clksrc) begin
      if (!resetb_clksrc) begin
         pending_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   // Holdoff timer: loaded while in FIRE, counts down through HOLD, stops at zero
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (state_q == FIRE) begin
         hold_cnt_d = HOLD_LOAD;
      end else if (state_q == HOLD && hold_cnt_q != '0) begin
         hold_cnt_d = hold_cnt_q - HCNT_W'(1);
      end
   end

   always_ff @(posedge clksrc or negedge resetb_clksrc) begin
      if (!resetb_clksrc) begin
         hold_cnt_q <= '0;
         pulse_q    <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         pulse_q    <= enter_fire;
      end
   end

   assign pulse_src = pulse_q;
   assign pending   = pending_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_src_gate.sv
// Self-checking bench for pulse_src_gate (CNT_W=2, HOLDOFF=4): per-cycle
// vector tables fed through an expected-value queue, plus reset sequences.
module tb_pulse_src_gate;

   localparam int CNT_W   = 2;
   localparam int HOLDOFF = 4;

   logic             clksrc = 1'b0;
   logic             resetb_clksrc;
   logic             ev_in;
   logic             clr_ovf;
   logic             pulse_src;
   logic [CNT_W-1:0] pending;
   logic             busy;
   logic             overflow;

   typedef struct {
      logic             ev;
      logic             clr;
      logic             pulse;
      logic [CNT_W-1:0] pend;
      logic             busy;
      logic             ovf;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   pulse_src_gate #(.CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
      .clksrc        (clksrc),
      .resetb_clksrc (resetb_clksrc),
      .ev_in         (ev_in),
      .clr_ovf       (clr_ovf),
      .pulse_src     (pulse_src),
      .pending       (pending),
      .busy          (busy),
      .overflow      (overflow)
   );

   always #5 clksrc = ~clksrc;

   task automatic check_val(input string name, input int idx, input logic [31:0] act,
                            input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic check_zero(input string name, input int idx);
      check_val({name, ".pulse_src"}, idx, 32'(pulse_src), 0);
      check_val({name, ".pending"},   idx, 32'(pending),   0);
      check_val({name, ".busy"},      idx, 32'(busy),      0);
      check_val({name, ".overflow"},  idx, 32'(overflow),  0);
   endtask

   task automatic add_vec(input int reps, input logic ev, input logic clr, input logic pulse,
                          input logic [CNT_W-1:0] pend, input logic bsy, input logic ovf);
      vec_t v;
      v.ev    = ev;
      v.clr   = clr;
      v.pulse = pulse;
      v.pend  = pend;
      v.busy  = bsy;
      v.ovf   = ovf;
      repeat (reps) tbl.push_back(v);
   endtask

   // Inputs for cycle n are driven just after its opening edge
   task automatic applyStimulus(input vec_t v);
      @(posedge clksrc);
      #1;
      ev_in   = v.ev;
      clr_ovf = v.clr;
      exp_q.push_back(v);
   endtask

   task automatic checkOutput(input string name, input int idx);
      vec_t e;
      @(negedge clksrc);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("[TB] FAIL %s step %0d: scoreboard empty", name, idx);
      end else begin
         e = exp_q.pop_front();
         check_val({name, ".pulse_src"}, idx, 32'(pulse_src), 32'(e.pulse));
         check_val({name, ".pending"},   idx, 32'(pending),   32'(e.pend));
         check_val({name, ".busy"},      idx, 32'(busy),      32'(e.busy));
         check_val({name, ".overflow"},  idx, 32'(overflow),  32'(e.ovf));
      end
   endtask

   task automatic run_table(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         checkOutput(name, i);
      end
      tbl.delete();
   endtask

   initial begin
      resetb_clksrc = 1'b0;
      ev_in         = 1'b1;
      clr_ovf       = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clksrc);
         check_zero("in_reset", i);
      end
      resetb_clksrc = 1'b1;
      ev_in         = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clksrc);
         check_zero("post_reset", i);
      end

      // reps, ev, clr, pulse, pending, busy, overflow
      add_vec(1, 1, 0, 0, 0, 0, 0);
      add_vec(1, 0, 0, 0, 1, 1, 0);
      add_vec(1, 0, 0, 1, 0, 1, 0);
      add_vec(4, 0, 0, 0, 0, 1, 0);
      add_vec(2, 0, 0, 0, 0, 0, 0);
      run_table("single");

      add_vec(1, 1, 0, 0, 0, 0, 0);
      add_vec(1, 1, 0, 0, 1, 1, 0);
      add_vec(1, 1, 0, 1, 1, 1, 0);
      add_vec(4, 0, 0, 0, 2, 1, 0);
      add_vec(1, 0, 0, 1, 1, 1, 0);
      add_vec(4, 0, 0, 0, 1, 1, 0);
      add_vec(1, 0, 0, 1, 0, 1, 0);
      add_vec(4, 0, 0, 0, 0, 1, 0);
      add_vec(1, 0, 0, 0, 0, 0, 0);
      run_table("burst3");

      add_vec(1, 1, 0, 0, 0, 0, 0);
      add_vec(1, 1, 0, 0, 1, 1, 0);
      add_vec(1, 1, 0, 1, 1, 1, 0);
      add_vec(1, 1, 0, 0, 2, 1, 0);
      add_vec(1, 1, 0, 0, 3, 1, 0);
      add_vec(1, 1, 0, 0, 3, 1, 1);
      add_vec(1, 0, 0, 0, 3, 1, 1);
      add_vec(1, 0, 0, 1, 2, 1, 1);
      add_vec(4, 0, 0, 0, 2, 1, 1);
      add_vec(1, 0, 0, 1, 1, 1, 1);
      add_vec(4, 0, 0, 0, 1, 1, 1);
      add_vec(1, 0, 0, 1, 0, 1, 1);
      add_vec(4, 0, 0, 0, 0, 1, 1);
      add_vec(1, 0, 1, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0, 0, 0, 0);
      run_table("saturate");

      add_vec(1, 1, 0, 0, 0, 0, 0);
      add_vec(1, 1, 0, 0, 1, 1, 0);
      add_vec(1, 1, 0, 1, 1, 1, 0);
      add_vec(1, 1, 0, 0, 2, 1, 0);
      add_vec(1, 1, 0, 0, 3, 1, 0);
      add_vec(1, 1, 1, 0, 3, 1, 1);
      add_vec(1, 0, 1, 0, 3, 1, 1);
      add_vec(1, 0, 0, 1, 2, 1, 0);
      add_vec(4, 0, 0, 0, 2, 1, 0);
      add_vec(1, 0, 0, 1, 1, 1, 0);
      add_vec(4, 0, 0, 0, 1, 1, 0);
      add_vec(1, 0, 0, 1, 0, 1, 0);
      add_vec(4, 0, 0, 0, 0, 1, 0);
      add_vec(1, 0, 0, 0, 0, 0, 0);
      run_table("clear_race");

      add_vec(1, 1, 0, 0, 0, 0, 0);
      add_vec(1, 1, 0, 0, 1, 1, 0);
      add_vec(1, 1, 0, 1, 1, 1, 0);
      add_vec(1, 0, 0, 0, 2, 1, 0);
      run_table("pre_reset");

      // Reset lands mid-cycle in HOLD with two events still pending
      @(posedge clksrc);
      #1;
      resetb_clksrc = 1'b0;
      #2;
      check_zero("reset_mid_hold", 0);
      @(negedge clksrc);
      resetb_clksrc = 1'b1;

      add_vec(15, 0, 0, 0, 0, 0, 0);
      run_table("after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
